// File: rtl/tree_operand_packer_if.sv
// Handshake bundle between the PE multiply stage, the operand packer and adder_tree.
// The packer connects through the slave modport. The producer/consumer side connects through the master modport.
interface tree_operand_packer_if #(
    parameter int WIDTH     = 32,
    parameter int INPUT_NUM = 8,
    parameter int CNT_W     = $clog2(INPUT_NUM + 1)
);
    logic                              in_valid;
    logic                              in_ready;
    logic [WIDTH-1:0]                  in_data;
    logic                              in_last;
    logic                              out_valid;
    logic                              out_ready;
    logic [INPUT_NUM-1:0][WIDTH-1:0]   out_data;
    logic [CNT_W-1:0]                  out_count;
    logic                              out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_last
    );
endinterface

// File: rtl/tree_operand_packer.sv
// Packs a serial product stream into zero-filled INPUT_NUM-lane vectors for adder_tree.
// Optional transfer statistics are enabled with the macro TREE_OPERAND_PACKER_STATS_EN.
module tree_operand_packer #(
    parameter int WIDTH     = 32,
    parameter int INPUT_NUM = 8,
    parameter int CNT_W     = $clog2(INPUT_NUM + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    tree_operand_packer_if.slave  bus
`ifdef TREE_OPERAND_PACKER_STATS_EN
    ,
    output logic [31:0]           stat_groups,
    output logic [31:0]           stat_partial
`endif
);

    localparam int PTR_W = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(INPUT_NUM - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic [INPUT_NUM-1:0][WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic                            last_q, last_d;

    logic inReady;
    logic inFire;

    // While holding a vector, an element is accepted only if the vector leaves this same cycle.
    assign inReady = (state_q == FILL) || bus.out_ready;
    assign inFire  = bus.in_valid && inReady;

    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = data_q;
    assign bus.out_count = count_q;
    assign bus.out_last  = last_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        count_d = count_q;
        last_d  = last_q;
        unique case (state_q)
            FILL: begin
                if (inFire) begin
                    data_d[ptr_q] = bus.in_data;
                    if ((ptr_q == LAST_PTR) || bus.in_last) begin
                        state_d = HOLD;
                        count_d = CNT_W'(ptr_q) + CNT_W'(1);
                        last_d  = bus.in_last;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    // Start a fresh zeroed vector so unused lanes never leak old products.
                    state_d = FILL;
                    data_d  = '0;
                    count_d = '0;
                    last_d  = 1'b0;
                    ptr_d   = '0;
                    if (inFire) begin
                        data_d[0] = bus.in_data;
                        if ((INPUT_NUM == 1) || bus.in_last) begin
                            state_d = HOLD;
                            count_d = CNT_W'(1);
                            last_d  = bus.in_last;
                        end else begin
                            ptr_d = PTR_W'(1);
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            ptr_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

`ifdef TREE_OPERAND_PACKER_STATS_EN
    logic [31:0] groups_q;
    logic [31:0] partial_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            groups_q  <= '0;
            partial_q <= '0;
        end else if ((state_q == HOLD) && bus.out_ready) begin
            groups_q <= groups_q + 32'd1;
            if (count_q < CNT_W'(INPUT_NUM)) begin
                partial_q <= partial_q + 32'd1;
            end
        end
    end

    assign stat_groups  = groups_q;
    assign stat_partial = partial_q;
`endif

endmodule

// File: tb/tb_tree_operand_packer.sv
// Self-checking bench for tree_operand_packer: directed scenarios plus randomized traffic
// checked against a queue-based group model.
module tb_tree_operand_packer;

    localparam int WIDTH     = 32;
    localparam int INPUT_NUM = 8;
    localparam int CNT_W     = $clog2(INPUT_NUM + 1);
    localparam int VW        = WIDTH * INPUT_NUM;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    tree_operand_packer_if #(.WIDTH(WIDTH), .INPUT_NUM(INPUT_NUM), .CNT_W(CNT_W)) bus ();

`ifdef TREE_OPERAND_PACKER_STATS_EN
    logic [31:0] stat_groups;
    logic [31:0] stat_partial;
`endif

    tree_operand_packer #(.WIDTH(WIDTH), .INPUT_NUM(INPUT_NUM), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef TREE_OPERAND_PACKER_STATS_EN
        ,
        .stat_groups  (stat_groups),
        .stat_partial (stat_partial)
`endif
    );

    typedef struct {
        logic [VW-1:0] data;
        int            count;
        bit            last;
    } vec_t;

    vec_t             expQ[$];
    logic [WIDTH-1:0] lanes[$];
    int               vectors     = 0;
    int               miscompares = 0;
    int unsigned      groupsModel  = 0;
    int unsigned      partialModel = 0;

    task automatic checkOutput(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every observable output with the model, then advance the model by one clock.
    task automatic observeAndStep(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit r);
        bit            expValid;
        bit            inFire;
        logic [VW-1:0] vd;
        vec_t          nv;
        expValid = (expQ.size() != 0);
        checkOutput("out_valid", VW'(bus.out_valid), VW'(expValid));
        checkOutput("in_ready", VW'(bus.in_ready), VW'(!expValid || r));
        if (expValid) begin
            checkOutput("out_data", bus.out_data, expQ[0].data);
            checkOutput("out_count", VW'(bus.out_count), VW'(expQ[0].count));
            checkOutput("out_last", VW'(bus.out_last), VW'(expQ[0].last));
        end
`ifdef TREE_OPERAND_PACKER_STATS_EN
        checkOutput("stat_groups", VW'(stat_groups), VW'(groupsModel));
        checkOutput("stat_partial", VW'(stat_partial), VW'(partialModel));
`endif
        inFire = v && (!expValid || r);
        if (expValid && r) begin
            groupsModel++;
            if (expQ[0].count < INPUT_NUM) partialModel++;
            void'(expQ.pop_front());
        end
        if (inFire) begin
            lanes.push_back(d);
            if ((lanes.size() == INPUT_NUM) || l) begin
                vd = '0;
                for (int i = 0; i < lanes.size(); i++) vd[i*WIDTH +: WIDTH] = lanes[i];
                nv.data  = vd;
                nv.count = lanes.size();
                nv.last  = l;
                expQ.push_back(nv);
                lanes.delete();
            end
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d, input bit l, input bit r);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = r;
        #1;
        observeAndStep(v, d, l, r);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_out_valid", VW'(bus.out_valid), '0);
        checkOutput("rst_out_count", VW'(bus.out_count), '0);
        checkOutput("rst_out_last", VW'(bus.out_last), '0);
        checkOutput("rst_out_data", bus.out_data, '0);
        expQ.delete();
        lanes.delete();
        groupsModel  = 0;
        partialModel = 0;
        rst = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        resetDut();

        // Full group, then partial group closed by in_last
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 5; i <= 7; i++) applyStimulus(1'b1, WIDTH'(i), (i == 7), 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Backpressure, then back-to-back accept of element 9
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, WIDTH'(i + 100), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd9, 1'b0, 1'b1);
        for (int i = 10; i <= 16; i++) applyStimulus(1'b1, WIDTH'(i), 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Streaming 24 elements
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, WIDTH'(i + 200), 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Last element on final lane
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, WIDTH'(i + 300), (i == 7), 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Reset mid-group
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, WIDTH'(i + 400), 1'b0, 1'b1);
        resetDut();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, WIDTH'(i + 500), 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Stats scenario: one full group plus one 3-element group
        resetDut();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, WIDTH'(i + 1), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, WIDTH'(i + 1), (i == 2), 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(3) != 0), $urandom, ($urandom_range(5) == 0),
                          ($urandom_range(2) != 0));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tree_operand_packer.md
Name: tree_operand_packer

Overview:
- Producer-side front end for adder_tree: accepts a serial stream of WIDTH-bit products with a valid/ready handshake.
- Packs the stream into INPUT_NUM-lane vectors and presents each vector on adder_tree's indata bus with a valid/ready handshake.
- Zero-fills unused lanes of a partial group so that the reduction sum is unaffected.
- Sits between the PE multiply stage and adder_tree in the convolution datapath.

Parameters:
- WIDTH, 32, bit width of each lane.
- INPUT_NUM, 8, lanes per output vector (>=1; must match adder_tree INPUT_NUM).
- CNT_W, $clog2(INPUT_NUM+1), width of the lane-count field.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  packer can accept an element.
- in_data  in  WIDTH  input element.
- in_last  in  1  element closes the current group (kernel window end).
- out_valid  out  1  packed vector valid.
- out_ready  in  1  adder_tree side accepts the vector.
- out_data  out  [INPUT_NUM-1:0][WIDTH-1:0]  packed vector; lane i = i-th element of the group.
- out_count  out  CNT_W  number of populated lanes (1..INPUT_NUM).
- out_last  out  1  group was closed by in_last (not by lane fill).

Behaviour:
- Reset (rst==0 at posedge): state=FILL, lane pointer=0, out_data all zero, out_valid=0, out_count=0, out_last=0. Reset overrides any in-progress group or pending output; the partial group is discarded.
- Handshakes: an input transfer occurs when in_valid&&in_ready; an output transfer occurs when out_valid&&out_ready. out_data/out_count/out_last are held stable while out_valid&&!out_ready.
- State FILL (out_valid=0, in_ready=1):
  - On an input transfer, write in_data to lane[ptr] and increment ptr.
  - If ptr==INPUT_NUM-1 or in_last: go to HOLD next cycle, out_valid=1, out_count=ptr+1, out_last=in_last, ptr=0.
- State HOLD (out_valid=1, in_ready=out_ready combinationally):
  - out_ready=0: hold all outputs; no input accepted.
  - out_ready=1 and no input transfer: go to FILL, clear out_data to zero, out_valid=0.
  - out_ready=1 and input transfer (back-to-back): the current vector completes and in_data is written to lane 0 of a fresh zeroed vector, ptr=1.
    - If INPUT_NUM==1 or in_last: stay in HOLD with the new vector (out_count=1, out_last=in_last).
    - Otherwise go to FILL.
- Zero fill: lanes >= out_count are always 0 when out_valid=1.
- Latency: the vector is valid one cycle after the input transfer that completes it. Sustained throughput is one element per cycle, with no bubble at group boundaries.
- in_last on lane INPUT_NUM-1: a single vector with out_count=INPUT_NUM and out_last=1. An empty group is never emitted.
- in_data is captured without arithmetic; width is unchanged.

Optional Feature:
- Macro: TREE_OPERAND_PACKER_STATS_EN.
- Defined:
  - Adds output stat_groups (32 bits), which counts output transfers.
  - Adds output stat_partial (32 bits), which counts output transfers with out_count<INPUT_NUM.
  - Both counters reset to 0 on rst==0 and wrap modulo 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Full group: 8 transfers of 1..8, out_ready=1 -> one vector {8,7,...,1}, out_count=8, out_last=0, out_valid one cycle after the 8th transfer.
- Partial group: 3 transfers 5,6,7 with in_last on the 3rd -> lanes0..2=5,6,7, lanes3..7=0, out_count=3, out_last=1.
- Backpressure: 8-element group complete, out_ready=0 for 4 cycles -> outputs stable and in_ready=0 throughout. out_ready=1 with in_valid=1 (data 9) -> vector accepted, and the next group starts with lane0=9.
- Streaming: 24 consecutive elements, out_ready=1 -> 3 vectors on consecutive 8-cycle boundaries with no lost or duplicated element.
- Reset mid-group: 4 elements accepted, then rst=0 for 1 cycle -> out_valid=0, ptr=0. The next 8 elements form a clean vector with no stale lanes.
- Stats (macro defined): one full group plus one 3-element in_last group -> stat_groups=2, stat_partial=1.
